// File: rtl/ts4231_pkg.sv
// ts4231_pkg: shared states, sync-code bit positions and ns-to-cycles helper for the TS4231 decoder.
// Rev 1.0
`default_nettype none

package ts4231_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HIGH = 3'd1,
    ARMED     = 3'd2,
    IN_PULSE  = 3'd3,
    CLASSIFY  = 3'd4
  } state_t;

  localparam int unsigned AXIS = 0;
  localparam int unsigned DATA = 1;
  localparam int unsigned SKIP = 2;

  function automatic int unsigned ns_to_cycles(input longint unsigned ns,
                                               input longint unsigned freq_hz);
    return 32'((ns * freq_hz) / 64'd1_000_000_000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ts4231_input_sync.sv
// ts4231_input_sync: 2-FF synchronizer and edge detect on the E envelope; short-pulse
// filter present only when TS4231_GLITCH_FILTER_EN is defined. Rev 1.0
`default_nettype none

module ts4231_input_sync #(
  parameter int unsigned GLITCH_MIN = 10
) (
  input  logic clock,
  input  logic reset_n,
  input  logic e_in,
  output logic e_sync,
  output logic fall,
  output logic rise,
  output logic glitch
);

  // sh[1] is the synchronized level, sh[2] its previous value; idle level is high
  logic [2:0] sh;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sh <= 3'b111;
    else          sh <= {sh[1:0], e_in};
  end

  assign e_sync = sh[1];
  assign fall   = sh[2] & ~sh[1];
  assign rise   = ~sh[2] & sh[1];

`ifdef TS4231_GLITCH_FILTER_EN
  localparam logic [15:0] GMIN = 16'(GLITCH_MIN);
  logic [15:0] lo_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        lo_cnt <= '0;
    else if (fall)                       lo_cnt <= 16'd1;
    else if (!sh[1] && lo_cnt != 16'hFFFF) lo_cnt <= lo_cnt + 16'd1;
  end

  assign glitch = rise && (lo_cnt < GMIN);
`else
  assign glitch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/ts4231_pulse_decoder.sv
// ts4231_pulse_decoder: decodes the TS4231 E envelope into Lighthouse v1 sync/sweep strobes.
// Rev 1.0. Build option TS4231_GLITCH_FILTER_EN discards very short low pulses.
`default_nettype none

module ts4231_pulse_decoder
  import ts4231_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned TS_WIDTH      = 20,
  parameter int unsigned SYNC_BASE_NS  = 62500,
  parameter int unsigned SYNC_STEP_NS  = 10417,
  parameter int unsigned SWEEP_MAX_NS  = 30000,
  parameter int unsigned IDLE_NS       = 2000,
  parameter int unsigned GLITCH_MIN_NS = 200
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                e_in,
  output logic                sync_valid,
  output logic [2:0]          sync_code,
  output logic                sweep_valid,
  output logic                sweep_axis,
  output logic [TS_WIDTH-1:0] sweep_time,
  output logic                pulse_error,
  output logic                busy
);

  localparam int unsigned BASE_CYC   = ns_to_cycles(64'(SYNC_BASE_NS), 64'(CLK_FREQ_HZ));
  localparam int unsigned STEP_CYC   = ns_to_cycles(64'(SYNC_STEP_NS), 64'(CLK_FREQ_HZ));
  localparam int unsigned SWMAX_CYC  = ns_to_cycles(64'(SWEEP_MAX_NS), 64'(CLK_FREQ_HZ));
  localparam int unsigned IDLE_CYC   = ns_to_cycles(64'(IDLE_NS), 64'(CLK_FREQ_HZ));
  localparam int unsigned GLITCH_CYC = ns_to_cycles(64'(GLITCH_MIN_NS), 64'(CLK_FREQ_HZ));

  localparam logic [15:0]         IDLE_LAST = 16'(IDLE_CYC - 1);
  localparam logic [15:0]         WIDTH_MAX = 16'hFFFF;
  localparam logic [TS_WIDTH-1:0] FRAME_MAX = '1;

  logic e_sync, fall, rise, glitch;

  ts4231_input_sync #(.GLITCH_MIN(GLITCH_CYC)) u_input_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .e_in    (e_in),
    .e_sync  (e_sync),
    .fall    (fall),
    .rise    (rise),
    .glitch  (glitch)
  );

  state_t              state, state_nx;
  logic [15:0]         width_cnt, idle_cnt;
  logic [TS_WIDTH-1:0] frame_cnt, edge_ts;
  logic                ref_valid, ref_axis;
  logic                sync_valid_nx, sweep_valid_nx, error_nx, ref_commit;
  logic                is_sweep, is_sync;
  logic [2:0]          sync_k;
  logic [31:0]         w32;

  // Width classes are windows of +/- STEP/2 around each code's nominal width
  always_comb begin
    w32      = {16'd0, width_cnt};
    is_sweep = (w32 < SWMAX_CYC);
    is_sync  = 1'b0;
    sync_k   = 3'd0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (w32 >= BASE_CYC + k * STEP_CYC - STEP_CYC / 2 &&
          w32 <  BASE_CYC + k * STEP_CYC + STEP_CYC / 2) begin
        is_sync = 1'b1;
        sync_k  = 3'(k);
      end
    end
  end

  always_comb begin
    state_nx       = state;
    sync_valid_nx  = 1'b0;
    sweep_valid_nx = 1'b0;
    error_nx       = 1'b0;
    ref_commit     = 1'b0;
    case (state)
      IDLE:      if (enable) state_nx = WAIT_HIGH;
      WAIT_HIGH: if (e_sync && idle_cnt == IDLE_LAST) state_nx = ARMED;
      ARMED:     if (fall) state_nx = IN_PULSE;
      IN_PULSE: begin
        if (rise) begin
          state_nx = CLASSIFY;
          if (glitch) begin
            state_nx = ARMED;
          end else if (is_sweep) begin
            if (ref_valid && edge_ts != FRAME_MAX) sweep_valid_nx = 1'b1;
            else                                   error_nx       = 1'b1;
          end else if (is_sync) begin
            sync_valid_nx = 1'b1;
            ref_commit    = ~sync_k[SKIP];
          end else begin
            error_nx = 1'b1;
          end
        end else if (width_cnt == WIDTH_MAX) begin
          error_nx = 1'b1;
          state_nx = WAIT_HIGH;
        end
      end
      CLASSIFY:  state_nx = ARMED;
      default:   state_nx = IDLE;
    endcase
    if (!enable) begin
      state_nx       = IDLE;
      sync_valid_nx  = 1'b0;
      sweep_valid_nx = 1'b0;
      error_nx       = 1'b0;
      ref_commit     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sync_valid  <= 1'b0;
      sweep_valid <= 1'b0;
      pulse_error <= 1'b0;
      sync_code   <= 3'd0;
      sweep_axis  <= 1'b0;
      sweep_time  <= '0;
      width_cnt   <= '0;
      idle_cnt    <= '0;
      frame_cnt   <= '0;
      edge_ts     <= '0;
      ref_valid   <= 1'b0;
      ref_axis    <= 1'b0;
    end else begin
      state       <= state_nx;
      sync_valid  <= sync_valid_nx;
      sweep_valid <= sweep_valid_nx;
      pulse_error <= error_nx;

      if (!enable) begin
        sync_code  <= 3'd0;
        sweep_axis <= 1'b0;
        sweep_time <= '0;
      end else begin
        if (sync_valid_nx) sync_code <= sync_k;
        if (sweep_valid_nx) begin
          sweep_axis <= ref_axis;
          sweep_time <= edge_ts;
        end
      end

      if (state == ARMED && fall)                            width_cnt <= 16'd1;
      else if (state == IN_PULSE && width_cnt != WIDTH_MAX)  width_cnt <= width_cnt + 16'd1;

      if (state == WAIT_HIGH && e_sync) idle_cnt <= idle_cnt + 16'd1;
      else                              idle_cnt <= '0;

      if (state == ARMED && fall) edge_ts <= frame_cnt;

      // Rebase as if the counter had been cleared to 1 at the sync falling edge
      if (ref_commit)                  frame_cnt <= TS_WIDTH'(width_cnt) + TS_WIDTH'(1);
      else if (frame_cnt != FRAME_MAX) frame_cnt <= frame_cnt + TS_WIDTH'(1);

      if (!enable)                     ref_valid <= 1'b0;
      else if (ref_commit)             ref_valid <= 1'b1;
      else if (frame_cnt == FRAME_MAX) ref_valid <= 1'b0;

      if (ref_commit) ref_axis <= sync_k[AXIS];
    end
  end

  assign busy = (state == ARMED) || (state == IN_PULSE);

endmodule

`default_nettype wire
